mem_data_arbiter: RTL
=====================

Name: mem_data_arbiter

Overview:
- Two-requester arbiter sharing the single data-memory port (dataMem: we, addr, data_in, data_out, write byte mask).
- Requester 0 is the core load/store unit. Requester 1 is a secondary master: DMA/loader/debug.
- Round-robin arbitration, optional bus lock for atomic sequences with bounded hold, and per-requester read-return routing.
- Sits between core/loader and dataMem in top.

Parameters:
- ADDR_WIDTH, 10, data-memory word address width
- DATA_WIDTH, 32, data word width
- TRANSFER_WIDTH, 4, byte-mask width (one bit per byte lane)
- LOCK_MAX, 8, maximum consecutive cycles one requester may hold a lock; range 1..255

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_i  in  2  request per requester (bit0 core, bit1 secondary)
- lock_i  in  2  lock request; meaningful only while the same requester's req_i is high
- we_i  in  2  write enable per requester
- addr0_i / addr1_i  in  ADDR_WIDTH  address per requester
- wdata0_i / wdata1_i  in  DATA_WIDTH  write data per requester
- mask0_i / mask1_i  in  TRANSFER_WIDTH  write byte mask per requester
- gnt_o  out  2  one-hot grant, combinational, same cycle as the accepted request
- rvalid_o  out  2  read data valid for requester, one cycle after the granted read
- rdata_o  out  DATA_WIDTH  read data, shared; qualified by rvalid_o
- mem_we_o  out  1  to dataMem we
- mem_addr_o  out  ADDR_WIDTH  to dataMem addr
- mem_wdata_o  out  DATA_WIDTH  to dataMem data_in
- mem_mask_o  out  TRANSFER_WIDTH  to dataMem write_transfer_i
- mem_rdata_i  in  DATA_WIDTH  from dataMem data_out; valid the cycle after address
- locked_o  out  1  high while the bus is held in a LOCK state

Behaviour:
- Clock and reset:
  - All state changes on the posedge clk.
  - When rst_n = 0 at the edge: state = IDLE, last_gnt = 1 (so requester 0 wins the first contention), lock_cnt = 0, rvalid_o = 2'b00, rdata_o = 0.
  - During reset: gnt_o = 0 and mem_we_o = 0, regardless of req_i.
- Grant is combinational:
  - At most one gnt_o bit per cycle. The granted requester's addr/wdata/mask/we drive mem_*_o in that same cycle.
  - With no grant: mem_we_o = 0; mem_addr/wdata/mask hold requester 0's values. These are don't-care, but must never cause a write.
- A transfer completes when req_i[i] & gnt_o[i] is high at a clock edge. The requester may change its address or deassert the next cycle.
- State machine:
  - IDLE
    - Single request: granted.
    - Both requesting: grant the requester that is not last_gnt.
    - On each grant, last_gnt is updated to the granted requester.
    - If the granted requester has lock_i high: go to LOCK0 or LOCK1 and set lock_cnt = 1.
  - LOCKn
    - Only requester n can be granted. The other requester is stalled (gnt 0).
    - Each granted cycle with lock_i[n] high increments lock_cnt.
    - Exit to IDLE when any of these holds:
      - lock_i[n] deasserts. That cycle is still arbitrated as IDLE, so the last locked access may be the unlocking one.
      - req_i[n] deasserts.
      - lock_cnt reaches LOCK_MAX.
    - On forced exit (LOCK_MAX reached): last_gnt = n, so the other requester gets priority next cycle if it is waiting.
- Read return:
  - A granted read (we_i[i] = 0) sets rvalid_o[i] = 1 in the next cycle, with rdata_o = mem_rdata_i. Otherwise rvalid_o = 0.
  - Back-to-back reads from alternating requesters each return on their own rvalid bit in order.
- Writes:
  - Forwarded unchanged.
  - mask = 0 is still granted; the write is a memory no-op; rvalid stays 0.
- lock_i without req_i: ignored.
- lock_i on a non-granted requester: ignored and does not reserve the bus.
- Reset asserted mid-lock: returns to IDLE immediately. Any pending rvalid is dropped (0 the next cycle).

Test Plan:
- Reset then req_i = 2'b11, both reads, addr0 = 0x010, addr1 = 0x020 -> cycle 0 gnt = 01, mem_addr = 0x010; cycle 1 gnt = 10, mem_addr = 0x020, rvalid = 01; cycle 2 rvalid = 10.
- Requester 1 writes wdata 0xDEADBEEF, mask 4'b0011, addr 0x3FF, alone -> gnt = 10 same cycle; mem_we = 1, mem_mask = 0011, mem_addr = 0x3FF; rvalid stays 00.
- Requester 0 holds lock with req_i = 11 for 5 cycles, then drops lock -> gnt = 01 for 5 cycles and locked_o = 1; next cycle gnt = 10.
- LOCK_MAX = 8, requester 1 holds lock indefinitely while requester 0 waits -> 8 grants to 1, then gnt = 01 the next cycle, locked_o falls.
- rst_n low for one cycle while in LOCK1 with a read in flight -> next cycle state IDLE, rvalid = 00, gnt = 0 during reset cycle.
- Simultaneous requests over 6 cycles with no lock -> strict alternation 01, 10, 01, 10, 01, 10; no cycle with gnt = 11.

Source files
------------

// File: rtl/mem_data_arbiter.sv
// Two-requester round-robin arbiter for the single data-memory port, with
// bounded bus lock for atomic sequences and per-requester read-return routing.
module mem_data_arbiter #(
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int TRANSFER_WIDTH = 4,
   parameter int LOCK_MAX       = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                req_i,
   input  logic [1:0]                lock_i,
   input  logic [1:0]                we_i,
   input  logic [ADDR_WIDTH-1:0]     addr0_i,
   input  logic [ADDR_WIDTH-1:0]     addr1_i,
   input  logic [DATA_WIDTH-1:0]     wdata0_i,
   input  logic [DATA_WIDTH-1:0]     wdata1_i,
   input  logic [TRANSFER_WIDTH-1:0] mask0_i,
   input  logic [TRANSFER_WIDTH-1:0] mask1_i,
   output logic [1:0]                gnt_o,
   output logic [1:0]                rvalid_o,
   output logic [DATA_WIDTH-1:0]     rdata_o,
   output logic                      mem_we_o,
   output logic [ADDR_WIDTH-1:0]     mem_addr_o,
   output logic [DATA_WIDTH-1:0]     mem_wdata_o,
   output logic [TRANSFER_WIDTH-1:0] mem_mask_o,
   input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
   output logic                      locked_o
);

   localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t     state_reg, state_next;
   logic       last_gnt_reg, last_gnt_next;
   logic [7:0] lock_cnt_reg, lock_cnt_next;
   logic [7:0] lock_cnt_inc;
   logic [1:0] rvalid_reg;
   logic [1:0] gnt;
   logic       owner;
   logic       hold;
   logic       winner;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         last_gnt_reg <= 1'b1;
         lock_cnt_reg <= 8'd0;
         rvalid_reg   <= 2'b00;
      end else begin
         state_reg    <= state_next;
         last_gnt_reg <= last_gnt_next;
         lock_cnt_reg <= lock_cnt_next;
         rvalid_reg   <= gnt & ~we_i;
      end
   end

   always_comb begin
      state_next    = IDLE;
      last_gnt_next = last_gnt_reg;
      lock_cnt_next = 8'd0;
      gnt           = 2'b00;
      owner         = (state_reg == LOCK1);
      lock_cnt_inc  = lock_cnt_reg + 8'd1;
      // Lock only continues while its owner still requests with lock held;
      // otherwise the cycle falls back to ordinary round-robin arbitration.
      hold          = (state_reg != IDLE) && req_i[owner] && lock_i[owner];

      if (!rst_n) begin
         gnt = 2'b00;
      end else if (hold) begin
         gnt = owner ? 2'b10 : 2'b01;
      end else if (req_i == 2'b11) begin
         gnt = last_gnt_reg ? 2'b01 : 2'b10;
      end else begin
         gnt = req_i;
      end

      winner = gnt[1];

      if (hold) begin
         if (lock_cnt_inc >= LOCK_MAX_C) begin
            // Forced release: the other requester wins the next contention.
            state_next    = IDLE;
            last_gnt_next = owner;
         end else begin
            state_next    = state_reg;
            lock_cnt_next = lock_cnt_inc;
         end
      end else if (gnt != 2'b00) begin
         last_gnt_next = winner;
         if (lock_i[winner] && (LOCK_MAX_C > 8'd1)) begin
            state_next    = winner ? LOCK1 : LOCK0;
            lock_cnt_next = 8'd1;
         end
      end
   end

   assign gnt_o       = gnt;
   assign locked_o    = (gnt != 2'b00) && lock_i[winner];
   assign mem_we_o    = (gnt != 2'b00) && we_i[winner];
   assign mem_addr_o  = gnt[1] ? addr1_i  : addr0_i;
   assign mem_wdata_o = gnt[1] ? wdata1_i : wdata0_i;
   assign mem_mask_o  = gnt[1] ? mask1_i  : mask0_i;

   // Memory data arrives the cycle after the address, aligned with rvalid.
   assign rvalid_o = rvalid_reg;
   assign rdata_o  = (rvalid_reg != 2'b00) ? mem_rdata_i : '0;

endmodule
